btn_sw_debouncer: RTL
=====================

# btn_sw_debouncer

Input-conditioning stage between the board pins (`btn_i[4:0]`, `sw_i[15:0]`) and the CPU-facing bus (`MIO_BUS` BTN/SW inputs). It synchronizes all inputs, debounces buttons per channel, and filters switches on a shared sample tick. It also produces one-cycle press pulses and sticky, software-clearable press events, so a game loop polling through the bus does not miss short presses.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button change is accepted; legal range ≥ 2.
- `SW_TICK`, default 2_000_000: period of the switch sample tick, in cycles; legal range ≥ 2.
- `clk` input 1: system clock (board clock; this block is not on `Clk_CPU`).
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `btn_i` input 5: raw buttons, asynchronous, active-high.
- `sw_i` input 16: raw switches, asynchronous.
- `evt_clr_i` input 5: write-1-to-clear strobe for `btn_event_o`, synchronous to `clk`.
- `btn_o` output 5: debounced button level.
- `btn_press_o` output 5: one-cycle pulse on each accepted 0→1 button transition.
- `btn_event_o` output 5: sticky press flag per button.
- `sw_o` output 16: filtered switch level.

## Operation
- **Synchronizer.** Every `btn_i`/`sw_i` bit passes through 2 flops (`s1`, `s2`); both reset to 0. Only `s2` is used downstream.
- **Button debounce.** Each of the 5 channels has a counter `cnt[i]` (width `$clog2(DEBOUNCE_CYCLES)`) and its own FSM.
  - States: STABLE when `s2 == btn_o`, PENDING when `s2 != btn_o`.
  - STABLE: `cnt` is held at 0.
  - PENDING: `cnt` increments each cycle.
  - If `s2` returns to `btn_o` before the threshold, `cnt` goes to 0 and no output changes (glitch rejected).
  - When `cnt == DEBOUNCE_CYCLES-1` and `s2` still differs: `btn_o[i] <= s2`, `cnt <= 0`.
  - `cnt` never wraps; the threshold compare fires first.
- **Press pulse.** `btn_press_o[i]` is registered high on the same edge that `btn_o[i]` goes 0→1, and low on every other cycle. Releases (1→0) produce no pulse.
- **Event flag.** Updated in this priority order:
  - `btn_press_o[i]` set condition → 1 (the set wins over a simultaneous `evt_clr_i[i]`).
  - `evt_clr_i[i]` → 0.
  - Otherwise hold.
  - Clearing a flag that is already 0 is harmless. A clear while `btn_o` is still held does not re-set the flag; only a new 0→1 transition does.
- **Switch filter.**
  - A shared tick counter counts 0..`SW_TICK-1` and wraps; `tick` is high when the count is `SW_TICK-1`.
  - On each tick: `sw_prev <= s2_sw`. If `s2_sw == sw_prev`, then `sw_o <= s2_sw`.
  - So `sw_o` changes only after two consecutive tick samples agree. Each bit is evaluated independently within the same vector compare.
- **Reset (async, any time).** Clears all sync flops, `cnt[*]`, the tick counter, `sw_prev`, `btn_o`, `btn_press_o`, `btn_event_o`, and `sw_o` to 0. A debounce in progress is abandoned; after reset deassertion the filters restart from 0.

## Timing
- Button accept latency: a clean edge on `btn_i` reaches `btn_o`/`btn_press_o` after 2 (sync) + `DEBOUNCE_CYCLES` clk edges.
- Any `s2` glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- `btn_event_o` rises on the same edge as `btn_press_o`. It falls on the edge after `evt_clr_i` is sampled, unless that edge is also a press edge.
- Switch latency: 2 sync cycles, plus the wait to the next tick, plus one further tick. Worst case is about 2 + 2·`SW_TICK` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Outputs are on `clk`; consumers on `Clk_CPU` sample levels/sticky flags only. `btn_press_o` is for same-domain use.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `SW_TICK`=3.
- **Reset values.** Assert `rst` mid-run with `btn_i`=5'h1F and `sw_i`=16'hFFFF. All outputs must go 0 immediately, without waiting for a clock edge. After release with inputs held, `btn_o` must reach 5'h1F exactly 6 cycles later, with one `btn_press_o` pulse of 5'h1F.
- **Glitch rejection.** Hold `btn_i[0]`=1 for 3 cycles, then 0. Required: `btn_o`, `btn_press_o`, and `btn_event_o` all remain 0 throughout.
- **Clean press then release.** Set `btn_i[2]`=1 and hold. Required: `btn_o[2]`=1 and a single-cycle `btn_press_o`=5'b00100 at cycle 6, with `btn_event_o[2]` set at cycle 6. Then release: `btn_o[2]`=0 six cycles later, no pulse, and `btn_event_o[2]` still 1.
- **Clear versus set collision.** Pulse `evt_clr_i[2]` on the exact cycle `btn_press_o[2]` is generated. Required: `btn_event_o[2]` stays 1. A clear one cycle later drives it to 0.
- **Switch filter.** Change `sw_i` from 16'h0000 to 16'hA5A5. Required: `sw_o`=16'hA5A5 only after two consecutive ticks both sample A5A5. A 1-tick blip to 16'h0001 must leave `sw_o` unchanged.

Source files
------------

// File: rtl/btn_sw_debouncer.sv
// Board-pin input conditioning: 2-flop synchronizers, per-button debounce with
// press pulse and sticky software-clearable press flag, tick-sampled switch filter.
module btn_sw_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SW_TICK         = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_i,
    input  logic [15:0] sw_i,
    input  logic [4:0]  evt_clr_i,
    output logic [4:0]  btn_o,
    output logic [4:0]  btn_press_o,
    output logic [4:0]  btn_event_o,
    output logic [15:0] sw_o
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TICK_W = $clog2(SW_TICK);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SW_TICK - 1);

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    logic [4:0]       btn_s1;
    logic [4:0]       btn_s2;
    logic [15:0]      sw_s1;
    logic [15:0]      sw_s2;

    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       state;
    logic [4:0]       accept;
    logic [4:0]       press_set;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [15:0]       sw_prev;
    logic [15:0]       sw_agree;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_i;
            sw_s2  <= sw_s1;
        end
    end

    // Channel state is implied by the synchronized input disagreeing with the output.
    always_comb begin
        state  = '0;
        accept = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            state[i]  = (btn_s2[i] != btn_o[i]) ? ST_PENDING : ST_STABLE;
            accept[i] = (state[i] == ST_PENDING) && (cnt[i] == CNT_LAST);
        end
    end

    assign press_set = accept & btn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (state[i] == ST_STABLE || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new press wins over a clear strobe landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_o       <= '0;
            btn_press_o <= '0;
            btn_event_o <= '0;
        end else begin
            btn_o       <= btn_o ^ accept;
            btn_press_o <= press_set;
            btn_event_o <= press_set | (btn_event_o & ~evt_clr_i);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Each switch bit updates only when two consecutive tick samples agree.
    assign sw_agree = ~(sw_s2 ^ sw_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_prev <= '0;
            sw_o    <= '0;
        end else if (tick) begin
            sw_prev <= sw_s2;
            sw_o    <= (sw_o & ~sw_agree) | (sw_s2 & sw_agree);
        end
    end

endmodule
